// File: rtl/sysid_check_pkg.sv
// sysid_check_pkg: shared state encoding, Avalon word addresses and counter widths
// Revision 1.0
`default_nettype none

package sysid_check_pkg;

  localparam int TCNT_W = 16;
  localparam int RCNT_W = 4;

  localparam logic ADDR_TS = 1'b0;
  localparam logic ADDR_ID = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_TS   = 3'd1,
    WAIT_TS = 3'd2,
    RD_ID   = 3'd3,
    WAIT_ID = 3'd4,
    CHECK   = 3'd5,
    FAIL    = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sysid_check_timer.sv
// sysid_check_timer: per-transaction timeout counter and sequence retry counter
// Revision 1.0
`default_nettype none

module sysid_check_timer
  import sysid_check_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int RETRIES = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clear,
  input  logic load,
  input  logic abort,
  output logic expired,
  output logic retry_zero
);

  logic [TCNT_W-1:0] tcount;
  logic [RCNT_W-1:0] rcount;

  // tcount holds the number of cycles already spent in the current transaction;
  // it returns to zero whenever a transaction ends, so every RD state starts at 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      tcount <= '0;
      rcount <= '0;
    end else begin
      if (!run || clear) begin
        tcount <= '0;
      end else begin
        tcount <= tcount + TCNT_W'(1);
      end

      if (load) begin
        rcount <= RCNT_W'(RETRIES);
      end else if (abort && (rcount != '0)) begin
        rcount <= rcount - RCNT_W'(1);
      end
    end
  end

  assign expired    = run && (tcount == TCNT_W'(TIMEOUT - 1));
  assign retry_zero = (rcount == '0);

endmodule

`default_nettype wire

// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: reads timestamp and system ID over Avalon-MM and compares them
// Revision 1.0
`default_nettype none

module sysid_check_ctrl
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID = 32'h64A4C5FC,
  parameter logic [31:0] EXPECTED_TS = 32'h0000_0000,
  parameter int          TIMEOUT     = 255,
  parameter int          RETRIES     = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic        av_readdatavalid,
  input  logic [31:0] av_readdata
);

  state_t state;
  logic   run;
  logic   in_rd;
  logic   complete;
  logic   expired;
  logic   abort;
  logic   retry_zero;
  logic   load;

  assign in_rd = (state == RD_TS) || (state == RD_ID);
  assign run   = in_rd || (state == WAIT_TS) || (state == WAIT_ID);

  // Data accepted in an RD state only alongside command acceptance; in IDLE,
  // CHECK and FAIL a readdatavalid never counts.
  assign complete = (in_rd && !av_waitrequest && av_readdatavalid) ||
                    (((state == WAIT_TS) || (state == WAIT_ID)) && av_readdatavalid);
  assign abort    = expired && !complete;
  assign load     = (state == IDLE) && start;
  assign busy     = (state != IDLE);

  sysid_check_timer #(
    .TIMEOUT(TIMEOUT),
    .RETRIES(RETRIES)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .clear     (complete || abort),
    .load      (load),
    .abort     (abort),
    .expired   (expired),
    .retry_zero(retry_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      av_read     <= 1'b0;
      av_address  <= ADDR_TS;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            state       <= RD_TS;
            av_read     <= 1'b1;
            av_address  <= ADDR_TS;
          end
        end
        RD_TS, WAIT_TS: begin
          if (complete) begin
            ts_value   <= av_readdata;
            state      <= RD_ID;
            av_read    <= 1'b1;
            av_address <= ADDR_ID;
          end else if (abort) begin
            if (retry_zero) begin
              state   <= FAIL;
              av_read <= 1'b0;
            end else begin
              state      <= RD_TS;
              av_read    <= 1'b1;
              av_address <= ADDR_TS;
            end
          end else if ((state == RD_TS) && !av_waitrequest) begin
            state   <= WAIT_TS;
            av_read <= 1'b0;
          end
        end
        RD_ID, WAIT_ID: begin
          if (complete) begin
            id_value <= av_readdata;
            state    <= CHECK;
            av_read  <= 1'b0;
          end else if (abort) begin
            if (retry_zero) begin
              state   <= FAIL;
              av_read <= 1'b0;
            end else begin
              state      <= RD_TS;
              av_read    <= 1'b1;
              av_address <= ADDR_TS;
            end
          end else if ((state == RD_ID) && !av_waitrequest) begin
            state   <= WAIT_ID;
            av_read <= 1'b0;
          end
        end
        CHECK: begin
          id_ok <= (id_value == EXPECTED_ID);
          ts_ok <= (ts_value == EXPECTED_TS);
          done  <= 1'b1;
          state <= IDLE;
        end
        FAIL: begin
          timeout_err <= 1'b1;
          id_ok       <= 1'b0;
          ts_ok       <= 1'b0;
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state   <= IDLE;
          av_read <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sysid_check_ctrl.sv
// tb_sysid_check_ctrl: directed sequences against a behavioural Avalon slave,
// with a scoreboard of expected results popped on every done pulse.
`default_nettype none

module tb_sysid_check_ctrl;

  localparam logic [31:0] GOOD_ID = 32'h64A4C5FC;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, id_ok, ts_ok, timeout_err;
  logic [31:0] id_value, ts_value;
  logic        av_address, av_read;
  logic        av_waitrequest   = 1'b0;
  logic        av_readdatavalid = 1'b0;
  logic [31:0] av_readdata      = 32'h0;

  int checks   = 0;
  int failures = 0;

  sysid_check_ctrl #(
    .TIMEOUT(8),
    .RETRIES(2)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .id_ok           (id_ok),
    .ts_ok           (ts_ok),
    .timeout_err     (timeout_err),
    .id_value        (id_value),
    .ts_value        (ts_value),
    .av_address      (av_address),
    .av_read         (av_read),
    .av_waitrequest  (av_waitrequest),
    .av_readdatavalid(av_readdatavalid),
    .av_readdata     (av_readdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, req);
    end
  endtask

  // Behavioural slave, reconfigured between steps
  logic [31:0] cfg_ts = 32'h0;
  logic [31:0] cfg_id = GOOD_ID;
  int          cfg_wait = 0;
  int          cfg_lat  = 0;
  int          cfg_drop = 0;
  bit          stale_req = 1'b0;
  int          wcnt = 0;
  int          pend = 0;
  logic        pend_addr = 1'b0;
  int          ts_cmds = 0;
  bit          prev_wait = 1'b0;
  logic        prev_addr = 1'b0;

  always @(negedge clock) begin
    av_waitrequest   = 1'b0;
    av_readdatavalid = 1'b0;
    if (prev_wait) begin
      check("hold_read", {31'b0, av_read}, 32'd1);
      check("hold_addr", {31'b0, av_address}, {31'b0, prev_addr});
    end
    prev_wait = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        av_readdatavalid = 1'b1;
        av_readdata      = pend_addr ? cfg_id : cfg_ts;
      end
    end
    if (stale_req) begin
      av_readdatavalid = 1'b1;
      av_readdata      = 32'hDEADBEEF;
      stale_req        = 1'b0;
    end
    if (av_read && !reset) begin
      if (wcnt < cfg_wait) begin
        av_waitrequest = 1'b1;
        wcnt++;
        prev_wait = 1'b1;
        prev_addr = av_address;
      end else begin
        wcnt = 0;
        if (av_address == 1'b0) ts_cmds++;
        if (cfg_drop > 0) begin
          cfg_drop--;
        end else if (cfg_lat == 0) begin
          av_readdatavalid = 1'b1;
          av_readdata      = av_address ? cfg_id : cfg_ts;
        end else begin
          pend      = cfg_lat;
          pend_addr = av_address;
        end
      end
    end
  end

  // Scoreboard
  typedef struct {
    logic        id_ok;
    logic        ts_ok;
    logic        terr;
    logic [31:0] idv;
    logic [31:0] tsv;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   start_cyc = 0;
  int   done_count = 0;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (done === 1'b1) begin
      done_count++;
      check("done_expected", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("id_ok", {31'b0, id_ok}, {31'b0, e.id_ok});
        check("ts_ok", {31'b0, ts_ok}, {31'b0, e.ts_ok});
        check("timeout_err", {31'b0, timeout_err}, {31'b0, e.terr});
        check("id_value", id_value, e.idv);
        check("ts_value", ts_value, e.tsv);
        check("latency", cyc - start_cyc, e.lat);
      end
    end
  end

  function automatic exp_t mk(input logic iok, input logic tok, input logic terr,
                              input logic [31:0] idv, input logic [31:0] tsv, input int lat);
    exp_t e;
    e.id_ok = iok; e.ts_ok = tok; e.terr = terr; e.idv = idv; e.tsv = tsv; e.lat = lat;
    return e;
  endfunction

  task automatic run_seq(input string name, input exp_t e);
    int n;
    @(negedge clock);
    start     = 1'b1;
    start_cyc = cyc;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    n = done_count;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      if (done_count != n) break;
    end
    repeat (3) @(negedge clock);
    check({name, "_done_once"}, done_count - n, 32'd1);
    check({name, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int n;

    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_flags", {29'b0, id_ok, ts_ok, timeout_err}, 32'd0);
    check("rst_id_value", id_value, 32'd0);
    check("rst_ts_value", ts_value, 32'd0);
    check("rst_av", {30'b0, av_read, av_address}, 32'd0);

    // Zero-wait, matching slave
    run_seq("pass", mk(1, 1, 0, GOOD_ID, 32'h0, 4));

    // Wrong system ID
    cfg_id = 32'h12345678;
    run_seq("bad_id", mk(0, 1, 0, 32'h12345678, 32'h0, 4));

    // Five waitrequest cycles per read
    cfg_id = GOOD_ID; cfg_wait = 5;
    run_seq("wait5", mk(1, 1, 0, GOOD_ID, 32'h0, 14));

    // No data ever: three attempts then timeout error
    cfg_wait = 0; cfg_drop = 100; ts_cmds = 0;
    run_seq("timeout", mk(0, 0, 1, GOOD_ID, 32'h0, 26));
    check("timeout_attempts", ts_cmds, 32'd3);

    // First attempt lost, retry succeeds
    cfg_drop = 1; ts_cmds = 0;
    run_seq("retry", mk(1, 1, 0, GOOD_ID, 32'h0, 12));
    check("retry_attempts", ts_cmds, 32'd2);

    // Stale readdatavalid while idle
    n = done_count;
    @(negedge clock);
    stale_req = 1'b1;
    repeat (3) @(negedge clock);
    check("stale_id_value", id_value, GOOD_ID);
    check("stale_ts_value", ts_value, 32'h0);
    check("stale_flags", {29'b0, id_ok, ts_ok, timeout_err}, 32'd6);
    check("stale_no_done", done_count - n, 32'd0);

    // Reset in WAIT_ID, with an ignored start while busy beforehand
    cfg_lat = 3; ts_cmds = 0; n = done_count;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (busy && av_address && !av_read) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_wait_id", {31'b0, found}, 32'd1);
    check("busy_start_ignored", ts_cmds, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_flags", {28'b0, done, id_ok, ts_ok, timeout_err}, 32'd0);
    check("mid_rst_values", id_value | ts_value, 32'd0);
    check("mid_rst_av", {30'b0, av_read, av_address}, 32'd0);
    repeat (6) @(negedge clock);
    check("mid_rst_no_done", done_count - n, 32'd0);
    check("late_rdv_ignored", id_value, 32'd0);
    check("late_rdv_idle", {31'b0, busy}, 32'd0);

    // Recovery with a wrong timestamp and one cycle of read latency
    cfg_lat = 1; cfg_ts = 32'h00000001;
    run_seq("bad_ts", mk(1, 0, 0, GOOD_ID, 32'h00000001, 6));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sysid_check_ctrl.md
SYSID_CHECK_CTRL -- requirements
Module: sysid_check_ctrl

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'h64A4C5FC: system ID value expected at slave address 1.
REQ-002 SHALL have parameter EXPECTED_TS, default 32'h0000_0000: timestamp value expected at slave address 0.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum cycles allowed per read transaction, range 1..65535.
REQ-004 SHALL have parameter RETRIES, default 3: sequence re-attempts after a timeout, range 0..15.
REQ-005 SHALL have port clock, input, 1 bit: single clock; all logic rising-edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: single-cycle pulse that requests a check sequence.
REQ-008 SHALL have port busy, output, 1 bit: high while a sequence is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when a sequence ends.
REQ-010 SHALL have ports id_ok and ts_ok, outputs, 1 bit each: comparison results, held until the next start.
REQ-011 SHALL have port timeout_err, output, 1 bit: retries exhausted, held until the next start.
REQ-012 SHALL have ports id_value and ts_value, outputs, 32 bits each: last captured read data.
REQ-013 SHALL have port av_address, output, 1 bit: slave word address (0 = timestamp, 1 = ID).
REQ-014 SHALL have port av_read, output, 1 bit: Avalon-MM read strobe.
REQ-015 SHALL have ports av_waitrequest and av_readdatavalid, inputs, 1 bit each.
REQ-016 SHALL have port av_readdata, input, 32 bits.

Function
REQ-017 SHALL implement states IDLE, RD_TS, WAIT_TS, RD_ID, WAIT_ID, CHECK, FAIL.
REQ-018 In IDLE, start SHALL clear id_ok, ts_ok and timeout_err, load the retry counter with RETRIES and enter RD_TS on the next cycle; start SHALL be ignored while busy.
REQ-019 RD_TS/RD_ID SHALL drive av_read=1 with av_address 0/1, hold both stable while av_waitrequest=1, and go to WAIT_TS/WAIT_ID on the first cycle where av_waitrequest=0.
REQ-020 WAIT_TS SHALL capture av_readdata into ts_value on av_readdatavalid=1, then enter RD_ID; WAIT_ID SHALL capture into id_value, then enter CHECK.
REQ-021 If readdatavalid arrives in the same cycle the command is accepted, it SHALL be captured and the corresponding WAIT state skipped.
REQ-022 CHECK SHALL set id_ok=(id_value==EXPECTED_ID), set ts_ok=(ts_value==EXPECTED_TS), pulse done and return to IDLE: fixed 1-cycle decision latency.
REQ-023 A 16-bit timeout counter SHALL clear on entry to each RD state and count every cycle in RD/WAIT states; reaching TIMEOUT SHALL abort the transaction.
REQ-024 On abort with retry counter >0, the counter SHALL decrement and the sequence SHALL restart at RD_TS; with counter 0, the FSM SHALL enter FAIL.
REQ-025 FAIL SHALL set timeout_err=1, pulse done, leave id_ok=ts_ok=0 and return to IDLE next cycle.
REQ-026 busy SHALL equal (state != IDLE); av_read SHALL be 0 outside RD states.
REQ-027 A late readdatavalid received in IDLE or after an abort SHALL be ignored.

Reset
REQ-028 reset SHALL force state IDLE, and set av_read, av_address, busy, done, id_ok, ts_ok and timeout_err to 0, id_value and ts_value to 0, and both counters to 0.
REQ-029 reset asserted mid-sequence SHALL take effect on the next edge with no done pulse.

Structure
REQ-030 State encoding, Avalon address constants (ADDR_TS=0, ADDR_ID=1) and counter widths SHALL reside in package sysid_check_pkg.
REQ-031 The timeout/retry counting SHALL be the single sub-module sysid_check_timer; all other logic SHALL be flat.

Verification
REQ-032 Zero-wait slave returning 0 at addr 0 and 32'h64A4C5FC at addr 1 -> done after the ID read completes, id_ok=1, ts_ok=1, timeout_err=0.
REQ-033 Slave returns 32'h12345678 at addr 1 -> id_ok=0, ts_ok=1, id_value=32'h12345678.
REQ-034 waitrequest held for 5 cycles on each read -> av_address and av_read stable throughout; result matches REQ-032.
REQ-035 TIMEOUT=8, RETRIES=2, no readdatavalid ever -> three RD_TS attempts, then timeout_err=1 and a single done pulse.
REQ-036 First attempt times out, second succeeds -> id_ok=1, timeout_err=0; a stale readdatavalid arriving afterwards does not change outputs.
REQ-037 reset pulsed while in WAIT_ID, then start pulsed during busy -> outputs return to reset values with no done pulse; the start during busy is ignored.
